// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer:
// states, opcodes, ALU_Op codes and datapath select values.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_EXEC_LUI,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_ALU,
    S_WB_MEM,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_R    = 3'b000;
  localparam logic [2:0] ALU_I    = 3'b001;
  localparam logic [2:0] ALU_LUI  = 3'b010;
  localparam logic [2:0] ALU_SW   = 3'b011;
  localparam logic [2:0] ALU_LW   = 3'b100;
  localparam logic [2:0] ALU_JALR = 3'b110;
  localparam logic [2:0] ALU_B    = 3'b111;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_REL   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  localparam logic IOD_PC  = 1'b0;
  localparam logic IOD_ALU = 1'b1;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Per-transfer wait counter; expires after TIMEOUT_CYCLES
// idle cycles so the sequencer can trap on a dead bus.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [7:0] LP_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] r_cnt;

  assign o_expired = (r_cnt == LP_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the multi-cycle RV32I core: steps each
// instruction through fetch/decode/execute/memory/write-back.
module multicycle_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_i,
  input  logic [6:0] opcode_i,
  input  logic       branch_taken_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       i_or_d_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       reg_write_o,
  output logic [1:0] wb_sel_o,
  output logic       alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic       bus_err_o
);

  state_t r_state;
  state_t w_next;
  state_t w_after;
  logic   r_illegal;
  logic   r_bus_err;
  logic   w_set_ill;
  logic   w_set_be;
  logic   w_expired;
  logic   w_store;

  assign w_after = run_i ? S_FETCH : S_IDLE;
  assign w_store = (opcode_i == OP_STORE);

  // counter restarts whenever the FSM changes state
  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .i_clr    (w_next != r_state),
    .i_en     (is_mem_state(r_state) && !mem_ready_i),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_ill) r_illegal <= 1'b1;
      if (w_set_be)  r_bus_err <= 1'b1;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_set_ill = 1'b0;
    w_set_be  = 1'b0;
    unique case (r_state)
      S_IDLE:     if (run_i) w_next = S_FETCH;
      S_FETCH: begin
        if (mem_ready_i) begin
          w_next = S_DECODE;
        end else if (w_expired) begin
          w_next   = S_TRAP;
          w_set_be = 1'b1;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          (opcode_i == OP_R):      w_next = S_EXEC_R;
          (opcode_i == OP_I):      w_next = S_EXEC_I;
          (opcode_i == OP_LUI):    w_next = S_EXEC_LUI;
          (opcode_i == OP_LOAD):   w_next = S_MEM_ADDR;
          (opcode_i == OP_STORE):  w_next = S_MEM_ADDR;
          (opcode_i == OP_BRANCH): w_next = S_BRANCH;
          (opcode_i == OP_JAL):    w_next = S_JAL;
          (opcode_i == OP_JALR):   w_next = S_JALR;
          default: begin
            w_next    = S_TRAP;
            w_set_ill = 1'b1;
          end
        endcase
      end
      S_EXEC_R,
      S_EXEC_I,
      S_EXEC_LUI: w_next = S_WB_ALU;
      S_MEM_ADDR: w_next = w_store ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD,
      S_MEM_WR: begin
        if (mem_ready_i) begin
          w_next = (r_state == S_MEM_RD) ? S_WB_MEM : w_after;
        end else if (w_expired) begin
          w_next   = S_TRAP;
          w_set_be = 1'b1;
        end
      end
      S_WB_ALU,
      S_WB_MEM,
      S_BRANCH,
      S_JAL,
      S_JALR:     w_next = w_after;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    i_or_d_o     = IOD_PC;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = PC_PLUS4;
    reg_write_o  = 1'b0;
    wb_sel_o     = WB_SEL_ALU;
    alu_src_b_o  = 1'b0;
    alu_op_o     = ALU_R;
    instr_done_o = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        mem_req_o  = 1'b1;
        ir_write_o = mem_ready_i;
        pc_write_o = mem_ready_i;
      end
      S_EXEC_I: begin
        alu_op_o    = ALU_I;
        alu_src_b_o = 1'b1;
      end
      S_EXEC_LUI: begin
        alu_op_o    = ALU_LUI;
        alu_src_b_o = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_op_o    = w_store ? ALU_SW : ALU_LW;
        alu_src_b_o = 1'b1;
      end
      S_MEM_RD: begin
        mem_req_o = 1'b1;
        i_or_d_o  = IOD_ALU;
        alu_op_o  = ALU_LW;
      end
      S_MEM_WR: begin
        mem_req_o    = 1'b1;
        mem_we_o     = 1'b1;
        i_or_d_o     = IOD_ALU;
        alu_op_o     = ALU_SW;
        instr_done_o = mem_ready_i;
      end
      S_WB_ALU: begin
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      S_WB_MEM: begin
        reg_write_o  = 1'b1;
        wb_sel_o     = WB_SEL_MEM;
        instr_done_o = 1'b1;
      end
      S_BRANCH: begin
        alu_op_o     = ALU_B;
        pc_write_o   = branch_taken_i;
        pc_src_o     = PC_REL;
        instr_done_o = 1'b1;
      end
      S_JAL: begin
        reg_write_o  = 1'b1;
        wb_sel_o     = WB_SEL_PC4;
        pc_write_o   = 1'b1;
        pc_src_o     = PC_REL;
        instr_done_o = 1'b1;
      end
      S_JALR: begin
        alu_op_o     = ALU_JALR;
        alu_src_b_o  = 1'b1;
        reg_write_o  = 1'b1;
        wb_sel_o     = WB_SEL_PC4;
        pc_write_o   = 1'b1;
        pc_src_o     = PC_ALU;
        instr_done_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal_o = r_illegal;
  assign bus_err_o = r_bus_err;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed scoreboard bench for the multi-cycle sequencer,
// built with TIMEOUT_CYCLES = 4 so the bus trap is reachable.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run_i = 1'b0;
  logic [6:0] opcode_i = 7'd0;
  logic       branch_taken_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       mem_req_o, mem_we_o, i_or_d_o, ir_write_o, pc_write_o;
  logic [1:0] pc_src_o, wb_sel_o;
  logic       reg_write_o, alu_src_b_o, instr_done_o, illegal_o, bus_err_o;
  logic [2:0] alu_op_o;

  multicycle_control_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .run_i(run_i), .opcode_i(opcode_i),
    .branch_taken_i(branch_taken_i), .mem_ready_i(mem_ready_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .i_or_d_o(i_or_d_o),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
    .reg_write_o(reg_write_o), .wb_sel_o(wb_sel_o),
    .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .instr_done_o(instr_done_o), .illegal_o(illegal_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] v;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  localparam logic [6:0] OPR = 7'b0110011, OPI = 7'b0010011;
  localparam logic [6:0] OPU = 7'b0110111, OPL = 7'b0000011;
  localparam logic [6:0] OPS = 7'b0100011, OPB = 7'b1100011;
  localparam logic [6:0] OPJ = 7'b1101111, OPJR = 7'b1100111;
  localparam logic [6:0] OPX = 7'b1111111;

  function automatic logic [16:0] actual();
    return {mem_req_o, mem_we_o, i_or_d_o, ir_write_o, pc_write_o,
            pc_src_o, reg_write_o, wb_sel_o, alu_src_b_o, alu_op_o,
            instr_done_o, illegal_o, bus_err_o};
  endfunction

  // packs fields in the same order as actual()
  function automatic logic [16:0] ev(
    input logic mreq, we, iod, irw, pcw, input logic [1:0] pcs,
    input logic rw, input logic [1:0] wbs, input logic srcb,
    input logic [2:0] aop, input logic done, ill, be);
    return {mreq, we, iod, irw, pcw, pcs, rw, wbs, srcb, aop, done, ill, be};
  endfunction

  function automatic void chk(input string nm, input logic [16:0] a,
                              input logic [16:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h", nm, a, e);
    end
  endfunction

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, actual(), e.v);
    end
  end

  task automatic cyc(input logic run, rdy, br, input logic [6:0] op,
                     input logic [16:0] e, input string nm);
    run_i = run;
    mem_ready_i = rdy;
    branch_taken_i = br;
    opcode_i = op;
    q.push_back('{v: e, nm: nm});
    @(posedge clk);
    #1;
  endtask

  logic [16:0] Z, FR, FW, WBA;
  initial begin
    Z   = '0;
    FR  = ev(1,0,0,1,1,2'b00,0,2'b00,0,3'b000,0,0,0);
    FW  = ev(1,0,0,0,0,2'b00,0,2'b00,0,3'b000,0,0,0);
    WBA = ev(0,0,0,0,0,2'b00,1,2'b00,0,3'b000,1,0,0);
  end

  initial begin
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, Z, "rst_low");
    reset = 1'b1;
    cyc(0, 1, 0, 0, Z, "idle_hold");
    cyc(1, 0, 0, 0, Z, "idle_run");
    // R-type, zero wait
    cyc(1, 1, 0, OPR, FR, "r_fetch");
    cyc(1, 1, 0, OPR, Z, "r_decode");
    cyc(1, 1, 0, OPR, Z, "r_exec");
    cyc(1, 1, 0, OPR, WBA, "r_wb");
    // I-type
    cyc(1, 1, 0, OPI, FR, "i_fetch");
    cyc(1, 1, 0, OPI, Z, "i_decode");
    cyc(1, 1, 0, OPI, ev(0,0,0,0,0,0,0,0,1,3'b001,0,0,0), "i_exec");
    cyc(1, 1, 0, OPI, WBA, "i_wb");
    // LW with 3 wait cycles
    cyc(1, 1, 0, OPL, FR, "lw_fetch");
    cyc(1, 1, 0, OPL, Z, "lw_decode");
    cyc(1, 1, 0, OPL, ev(0,0,0,0,0,0,0,0,1,3'b100,0,0,0), "lw_addr");
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 0, OPL, ev(1,0,1,0,0,0,0,0,0,3'b100,0,0,0), "lw_wait");
    cyc(1, 1, 0, OPL, ev(1,0,1,0,0,0,0,0,0,3'b100,0,0,0), "lw_rd");
    cyc(1, 1, 0, OPL, ev(0,0,0,0,0,0,1,2'b01,0,3'b000,1,0,0), "lw_wb");
    // SW
    cyc(1, 1, 0, OPS, FR, "sw_fetch");
    cyc(1, 1, 0, OPS, Z, "sw_decode");
    cyc(1, 1, 0, OPS, ev(0,0,0,0,0,0,0,0,1,3'b011,0,0,0), "sw_addr");
    cyc(1, 1, 0, OPS, ev(1,1,1,0,0,0,0,0,0,3'b011,1,0,0), "sw_wr");
    // LUI
    cyc(1, 1, 0, OPU, FR, "lui_fetch");
    cyc(1, 1, 0, OPU, Z, "lui_decode");
    cyc(1, 1, 0, OPU, ev(0,0,0,0,0,0,0,0,1,3'b010,0,0,0), "lui_exec");
    cyc(1, 1, 0, OPU, WBA, "lui_wb");
    // BEQ not taken, then taken
    cyc(1, 1, 1, OPB, FR, "bnt_fetch");
    cyc(1, 1, 1, OPB, Z, "bnt_decode");
    cyc(1, 1, 0, OPB, ev(0,0,0,0,0,2'b01,0,0,0,3'b111,1,0,0), "bnt_br");
    cyc(1, 1, 0, OPB, FR, "bt_fetch");
    cyc(1, 1, 0, OPB, Z, "bt_decode");
    cyc(1, 1, 1, OPB, ev(0,0,0,0,1,2'b01,0,0,0,3'b111,1,0,0), "bt_br");
    // JAL
    cyc(1, 1, 0, OPJ, FR, "jal_fetch");
    cyc(1, 1, 0, OPJ, Z, "jal_decode");
    cyc(1, 1, 0, OPJ, ev(0,0,0,0,1,2'b01,1,2'b10,0,3'b000,1,0,0), "jal");
    // LW whose ready arrives exactly at the timeout count
    cyc(1, 1, 0, OPL, FR, "lw2_fetch");
    cyc(1, 1, 0, OPL, Z, "lw2_decode");
    cyc(1, 1, 0, OPL, ev(0,0,0,0,0,0,0,0,1,3'b100,0,0,0), "lw2_addr");
    for (int i = 0; i < 4; i++)
      cyc(1, 0, 0, OPL, ev(1,0,1,0,0,0,0,0,0,3'b100,0,0,0), "lw2_wait");
    cyc(1, 1, 0, OPL, ev(1,0,1,0,0,0,0,0,0,3'b100,0,0,0), "lw2_ready_wins");
    cyc(1, 1, 0, OPL, ev(0,0,0,0,0,0,1,2'b01,0,3'b000,1,0,0), "lw2_wb");
    // JALR, run dropped on the final cycle
    cyc(1, 1, 0, OPJR, FR, "jalr_fetch");
    cyc(0, 1, 0, OPJR, Z, "jalr_decode");
    cyc(0, 1, 0, OPJR, ev(0,0,0,0,1,2'b10,1,2'b10,1,3'b110,1,0,0), "jalr");
    cyc(0, 1, 0, OPJR, Z, "idle_after_jalr");
    // async reset while fetching
    cyc(1, 0, 0, 0, Z, "idle_run2");
    cyc(1, 0, 0, 0, FW, "fetch_pre_rst");
    #1;
    reset = 1'b0;
    #1;
    chk("rst_async", actual(), Z);
    @(posedge clk);
    #1;
    cyc(1, 1, 0, 0, Z, "rst_held");
    reset = 1'b1;
    cyc(0, 0, 0, 0, Z, "idle_post_rst");
    cyc(1, 0, 0, 0, Z, "idle_run3");
    // bus timeout: ready never comes in FETCH
    for (int i = 0; i < 5; i++)
      cyc(1, 0, 0, 0, FW, "to_fetch_wait");
    cyc(1, 0, 0, 0, ev(0,0,0,0,0,0,0,0,0,0,0,0,1), "trap_bus");
    cyc(1, 1, 1, OPR, ev(0,0,0,0,0,0,0,0,0,0,0,0,1), "trap_bus_hold");
    // illegal opcode
    reset = 1'b0;
    cyc(0, 0, 0, 0, Z, "rst2");
    reset = 1'b1;
    cyc(1, 0, 0, 0, Z, "idle_run4");
    cyc(1, 1, 0, OPX, FR, "ill_fetch");
    cyc(1, 1, 0, OPX, Z, "ill_decode");
    cyc(1, 1, 0, OPX, ev(0,0,0,0,0,0,0,0,0,0,0,1,0), "trap_ill");
    cyc(1, 1, 1, OPR, ev(0,0,0,0,0,0,0,0,0,0,0,1,0), "trap_ill_hold");
    repeat (3) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, need 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Main sequencer for the multi-cycle RV32I core: a Moore FSM that steps every instruction through fetch, decode, execute, memory and write-back over several clock cycles, sharing one memory port and one ALU. It sits above the datapath and drives the 3-bit ALU_Op code consumed by the ALU control decoder. It also drives PC/IR/register-file write enables, datapath mux selects and a request/ready handshake to the unified memory.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum wait cycles per memory transfer before a bus-error trap; must be 1..255.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset (decided: one clock; reset asynchronous and active-low).
- run_i  in  1  permits starting a new instruction.
- opcode_i  in  7  IR[6:0]; valid from DECODE onward.
- branch_taken_i  in  1  datapath compare result for the current B-type instruction.
- mem_ready_i  in  1  memory completes the requested transfer this cycle.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  request is a write.
- i_or_d_o  out  1  memory address source: 0 = PC, 1 = ALU result register.
- ir_write_o  out  1  load IR and old_pc.
- pc_write_o  out  1  load PC.
- pc_src_o  out  2  PC source: 00 = PC+4, 01 = old_pc+imm, 10 = ALU result with bit 0 cleared.
- reg_write_o  out  1  register-file write.
- wb_sel_o  out  2  write-back source: 00 = ALU result, 01 = memory data, 10 = old_pc+4.
- alu_src_b_o  out  1  ALU operand B: 0 = rs2, 1 = immediate.
- alu_op_o  out  3  ALU_Op: R 000, I 001, LUI 010, SW 011, LW 100, JALR 110, B 111.
- instr_done_o  out  1  one-cycle pulse on the final cycle of each instruction.
- illegal_o  out  1  sticky: unsupported opcode.
- bus_err_o  out  1  sticky: memory timeout.

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, EXEC_LUI, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL, JALR, TRAP.
- Outputs are a pure function of state plus mem_ready_i and branch_taken_i. Every output is 0 in IDLE and TRAP unless stated below.
- IDLE: moves to FETCH when run_i = 1.
- FETCH:
  - Asserts mem_req_o with i_or_d_o = 0.
  - On mem_ready_i: pulses ir_write_o and pc_write_o (pc_src_o = 00), then moves to DECODE.
- DECODE: dispatches on opcode_i:
  - 0110011 → EXEC_R; 0010011 → EXEC_I; 0110111 → EXEC_LUI.
  - 0000011 or 0100011 → MEM_ADDR.
  - 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR.
  - Anything else → TRAP with illegal_o set.
- EXEC_R, EXEC_I, EXEC_LUI: drive alu_op_o 000/001/010 respectively; alu_src_b_o = 1 for I and LUI; next state WB_ALU.
- MEM_ADDR: alu_op_o = 100 (load) or 011 (store), alu_src_b_o = 1; next state MEM_RD (load) or MEM_WR (store).
- MEM_RD / MEM_WR:
  - Hold mem_req_o with i_or_d_o = 1; mem_we_o = 1 in MEM_WR only.
  - Keep the MEM_ADDR alu_op_o value.
  - On mem_ready_i: MEM_RD → WB_MEM; MEM_WR ends the instruction.
- WB_ALU / WB_MEM: reg_write_o with wb_sel_o = 00 / 01; ends the instruction.
- BRANCH: alu_op_o = 111; pc_write_o = branch_taken_i with pc_src_o = 01; ends the instruction.
- JAL: reg_write_o with wb_sel_o = 10, pc_write_o with pc_src_o = 01; ends the instruction.
- JALR: alu_op_o = 110, alu_src_b_o = 1, reg_write_o with wb_sel_o = 10, pc_write_o with pc_src_o = 10; ends the instruction.
- End of instruction:
  - instr_done_o = 1 on that cycle.
  - Next state is FETCH if run_i = 1, else IDLE.
- Memory handshake:
  - While mem_req_o = 1, mem_we_o and i_or_d_o are stable.
  - The transfer completes on the first rising edge that samples mem_ready_i = 1.
  - mem_ready_i is ignored whenever mem_req_o = 0.
- Timeout:
  - An 8-bit wait counter clears on entry to each memory state and increments each cycle that mem_ready_i = 0.
  - If mem_ready_i is still 0 when the count equals TIMEOUT_CYCLES, the FSM goes to TRAP and sets bus_err_o.
  - A ready arriving in that same cycle wins.
- TRAP is absorbing until reset; illegal_o and bus_err_o stay 1.

## Timing
- Reset (asynchronous, active-low): state goes to IDLE immediately, the wait counter clears to 0, and every output reads 0 while reset is low. This is the reset value of all outputs.
- Cycles per instruction with zero-wait memory (mem_ready_i tied to 1):
  - R/I/LUI: 4. LW: 5. SW: 4. B/JAL/JALR: 3.
  - Each memory wait cycle adds one.
- Reset mid-transfer: mem_req_o drops asynchronously; no write-enable pulses complete.
- run_i is sampled only in IDLE and on end-of-instruction cycles. Deasserting it mid-instruction does not abort the instruction.

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum (4 bits);
  - opcode constants and ALU_Op codes;
  - pc_src, wb_sel and i_or_d encodings.
- Sub-module mem_wait_timer: the 8-bit counter with clear, enable and expired outputs, parameterised by TIMEOUT_CYCLES.
- FSM is a next-state block plus a separate output-decode block.

## Test plan
- Reset low mid-FETCH with mem_req_o = 1 → all outputs 0 at once; state IDLE after release; FETCH one cycle after run_i = 1.
- R-type (0110011), ready tied to 1 → alu_op_o = 000 in EXEC_R, reg_write_o with wb_sel_o = 00 in cycle 4, instr_done_o in cycle 4, FETCH in cycle 5.
- LW with 3 wait cycles in MEM_RD → mem_req_o = 1 and i_or_d_o = 1 for 4 cycles, then WB_MEM with wb_sel_o = 01; total 8 cycles.
- BEQ with branch_taken_i = 0, then 1 → pc_write_o = 0, then pc_write_o = 1 with pc_src_o = 01; alu_op_o = 111; 3 cycles each.
- JALR → in one cycle: alu_op_o = 110, reg_write_o with wb_sel_o = 10, pc_write_o with pc_src_o = 10.
- TIMEOUT_CYCLES = 4, ready never asserted in FETCH → TRAP, bus_err_o = 1 on the sixth cycle after FETCH entry, all strobes 0 afterwards; opcode 1111111 in DECODE → illegal_o = 1.
